priv_i2c_master: RTL and testbench

Register-access I2C controller that drives the bus side opposite `priv_i2c_slave`. On a single-cycle request it performs one complete transaction, then pulses `done`.
- A register write is START, address+W, index, data, STOP.
- A register read is START, address+W, index, repeated START, address+R, one data byte returned with master NACK, STOP.

It sits between on-chip control logic and the open-drain SCL/SDA pads. The pad cells handle release/pull-low and the pull-ups.

---
 rtl/priv_i2c_master.sv | 162 ++++++++++++++++
 tb/tb_priv_i2c_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_i2c_master.sv
// Register-access I2C master: one register write or one single-byte register read per request.
// Every bus phase is four prescaled quarters; SCL/SDA are open-drain enables for the pad cells.
module priv_i2c_master #(
    parameter int         CLK_DIV  = 16,
    parameter logic [6:0] DEV_ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       i2c_rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] reg_idx,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_IDX, S_WDATA, S_RESTART, S_ADDR_R, S_RDATA, S_STOP
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [1:0]  q, q_n;
    logic [3:0]  bit_cnt, bit_n;
    logic [15:0] presc;
    logic        rw_r;
    logic [7:0]  idx_r, wdata_r, shreg;
    logic [7:0]  tx_n;
    logic [1:0]  bus_n;
    logic        accept, tick, sending;

    function automatic logic [7:0] tx_byte(state_t st, logic [7:0] idx, logic [7:0] wd);
        case (st)
            S_ADDR_W: tx_byte = {DEV_ADDR, 1'b0};
            S_IDX:    tx_byte = idx;
            S_WDATA:  tx_byte = wd;
            S_ADDR_R: tx_byte = {DEV_ADDR, 1'b1};
            default:  tx_byte = 8'h00;
        endcase
    endfunction

    // Returns {scl_oe, sda_oe} for a given quarter of a given phase.
    function automatic logic [1:0] bus_levels(state_t st, logic [1:0] qq, logic [3:0] b,
                                              logic [7:0] tx);
        logic master_bit;
        master_bit = (st == S_ADDR_W) || (st == S_IDX) || (st == S_WDATA) || (st == S_ADDR_R);
        case (st)
            S_START:   bus_levels = {1'b0, qq >= 2'd2};
            S_RESTART: bus_levels = (qq == 2'd0) ? 2'b10 : (qq == 2'd1) ? 2'b00 : 2'b01;
            S_STOP:    bus_levels = (qq == 2'd0) ? 2'b11 : (qq == 2'd1) ? 2'b01 : 2'b00;
            S_ADDR_W, S_IDX, S_WDATA, S_ADDR_R, S_RDATA: begin
                bus_levels[1] = (qq < 2'd2);
                bus_levels[0] = master_bit && (b < 4'd8) && !tx[3'd7 - b[2:0]];
            end
            default:   bus_levels = 2'b00;
        endcase
    endfunction

    assign accept  = (state == S_IDLE) && start;
    assign tick    = (state != S_IDLE) && (presc == PRESC_MAX);
    assign sending = (state == S_ADDR_W) || (state == S_IDX) || (state == S_WDATA) ||
                     (state == S_ADDR_R);
    assign done    = (state == S_STOP) && (q == 2'd3) && tick;
    assign busy    = (state != S_IDLE) && !done;

    always_comb begin
        state_n = state;
        q_n     = q;
        bit_n   = bit_cnt;
        if (accept) begin
            state_n = S_START;
            q_n     = 2'd0;
            bit_n   = 4'd0;
        end else if (tick) begin
            q_n = q + 2'd1;
            if (q == 2'd3) begin
                case (state)
                    S_START: begin
                        state_n = S_ADDR_W;
                        bit_n   = 4'd0;
                    end
                    S_ADDR_W, S_IDX, S_WDATA, S_ADDR_R: begin
                        if (bit_cnt != 4'd8) begin
                            bit_n = bit_cnt + 4'd1;
                        end else begin
                            bit_n = 4'd0;
                            // A NACK on any master-sent byte abandons the rest of the transfer.
                            if (ack_err)                state_n = S_STOP;
                            else if (state == S_ADDR_W) state_n = S_IDX;
                            else if (state == S_IDX)    state_n = rw_r ? S_RESTART : S_WDATA;
                            else if (state == S_WDATA)  state_n = S_STOP;
                            else                        state_n = S_RDATA;
                        end
                    end
                    S_RESTART: begin
                        state_n = S_ADDR_R;
                        bit_n   = 4'd0;
                    end
                    S_RDATA: begin
                        if (bit_cnt != 4'd8) begin
                            bit_n = bit_cnt + 4'd1;
                        end else begin
                            bit_n   = 4'd0;
                            state_n = S_STOP;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    assign tx_n  = tx_byte(state_n, idx_r, wdata_r);
    assign bus_n = bus_levels(state_n, q_n, bit_n, tx_n);

    always_ff @(posedge clk) begin
        if (i2c_rst) begin
            state   <= S_IDLE;
            q       <= 2'd0;
            bit_cnt <= 4'd0;
            presc   <= 16'd0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            q       <= q_n;
            bit_cnt <= bit_n;
            scl_oe  <= bus_n[1];
            sda_oe  <= bus_n[0];
            if (accept || tick)
                presc <= 16'd0;
            else if (state != S_IDLE)
                presc <= presc + 16'd1;
            if (accept)
                ack_err <= 1'b0;
            else if (tick && q == 2'd2 && sending && bit_cnt == 4'd8 && sda_in)
                ack_err <= 1'b1;
            if (tick && q == 2'd3 && state == S_RDATA && bit_cnt == 4'd8)
                rdata <= shreg;
        end
    end

    // Request operands and the receive shifter carry no reset; they are qualified by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            rw_r    <= rw;
            idx_r   <= reg_idx;
            wdata_r <= wdata;
        end
        if (tick && q == 2'd2 && state == S_RDATA && bit_cnt < 4'd8)
            shreg <= {shreg[6:0], sda_in};
    end

endmodule

// File: tb/tb_priv_i2c_master.sv
// Directed bench for priv_i2c_master: a register-file I2C slave model at 0x55 on a shared
// bus, byte logging, transaction timing and SCL/SDA protocol observation.
module tb_priv_i2c_master;

    localparam logic [6:0] SLV_ADDR = 7'h55;
    localparam int Q1 = 4;
    localparam int Q2 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2, rw;
    logic [7:0] reg_idx, wdata;
    logic       busy1, done1, ackerr1, scl1, sda1, sdain1;
    logic       busy2, done2, ackerr2, scl2, sda2, sdain2;
    logic [7:0] rdata1, rdata2;

    always #5 clk = ~clk;

    priv_i2c_master #(.CLK_DIV(Q1), .DEV_ADDR(7'h55)) dut (
        .clk(clk), .i2c_rst(rst), .start(start1), .rw(rw), .reg_idx(reg_idx), .wdata(wdata),
        .busy(busy1), .done(done1), .ack_err(ackerr1), .rdata(rdata1),
        .scl_oe(scl1), .sda_oe(sda1), .sda_in(sdain1));

    priv_i2c_master #(.CLK_DIV(Q2), .DEV_ADDR(7'h56)) dut_bad (
        .clk(clk), .i2c_rst(rst), .start(start2), .rw(rw), .reg_idx(reg_idx), .wdata(wdata),
        .busy(busy2), .done(done2), .ack_err(ackerr2), .rdata(rdata2),
        .scl_oe(scl2), .sda_oe(sda2), .sda_in(sdain2));

    // Bus wiring: the slave model sits on whichever master `sel` picks.
    logic sel;
    logic pull;
    logic scl_l, sda_l;
    assign scl_l  = ~(sel ? scl2 : scl1);
    assign sda_l  = ~(sel ? sda2 : sda1) & ~pull;
    assign sdain1 = sel ? ~sda1 : sda_l;
    assign sdain2 = sel ? sda_l : ~sda2;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model state
    logic       p_scl, p_sda, act, rd, rd_pend, mack;
    logic [3:0] bitn;
    logic [7:0] sh, ptr;
    int         nbyte;
    int         cond_cnt;
    logic [7:0] regs [256];
    logic [7:0] logq [$];

    // High-time observer
    int hi_cnt, viol;
    logic track;

    initial begin
        p_scl = 1'b1; p_sda = 1'b1; act = 1'b0; rd = 1'b0; rd_pend = 1'b0; mack = 1'b0;
        bitn = 4'd0; sh = 8'h00; ptr = 8'h00; nbyte = 0; cond_cnt = 0; pull = 1'b0;
        hi_cnt = 0; viol = 0; track = 1'b0;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    end

    always @(negedge clk) begin
        p_scl <= scl_l;
        p_sda <= sda_l;
        if (scl_l && p_scl && (sda_l != p_sda)) begin
            cond_cnt <= cond_cnt + 1;
            pull     <= 1'b0;
            if (!sda_l) begin
                act <= 1'b1; bitn <= 4'd0; nbyte <= 0; rd <= 1'b0; rd_pend <= 1'b0;
            end else begin
                act <= 1'b0; rd <= 1'b0;
            end
        end else if (act && scl_l && !p_scl) begin
            if (bitn < 4'd8 && !rd) sh <= {sh[6:0], sda_l};
            if (bitn == 4'd8 && rd) mack <= sda_l;
            bitn <= bitn + 4'd1;
        end else if (act && !scl_l && p_scl) begin
            if (bitn == 4'd8 && !rd) begin
                logq.push_back(sh);
                if (nbyte == 0) begin
                    if (sh[7:1] == SLV_ADDR) begin
                        pull <= 1'b1; rd_pend <= sh[0];
                    end else begin
                        act <= 1'b0;
                    end
                end else begin
                    pull <= 1'b1;
                    if (nbyte == 1) ptr <= sh;
                    else begin regs[ptr] <= sh; ptr <= ptr + 8'd1; end
                end
            end else if (bitn == 4'd8 && rd) begin
                pull <= 1'b0;
            end else if (bitn == 4'd9) begin
                bitn  <= 4'd0;
                nbyte <= nbyte + 1;
                if (rd_pend && !rd) begin
                    rd <= 1'b1; rd_pend <= 1'b0; pull <= ~regs[ptr][7];
                end else if (rd) begin
                    rd <= 1'b0; act <= 1'b0; pull <= 1'b0;
                end else begin
                    pull <= 1'b0;
                end
            end else if (rd && bitn < 4'd8) begin
                pull <= ~regs[ptr][3'd7 - bitn[2:0]];
            end
        end
    end

    always @(negedge clk) begin
        if (scl_l && !p_scl) begin
            hi_cnt <= 1; track <= 1'b1;
        end else if (scl_l) begin
            hi_cnt <= hi_cnt + 1;
        end else if (p_scl && track) begin
            track <= 1'b0;
            if (hi_cnt < 2 * (sel ? Q2 : Q1)) viol <= viol + 1;
        end
    end

    int npass = 0, ntotal = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_bytes(input string tag, input int l0, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] e [3];
        e = '{b0, b1, b2};
        check({tag, "_nbytes"}, logq.size() - l0, n);
        for (int i = 0; i < n; i++)
            check({tag, "_byte"}, (l0 + i < logq.size()) ? logq[l0 + i] : 8'hxx, e[i]);
    endtask

    task automatic txn(input logic which, input logic r, input logic [7:0] idx,
                       input logic [7:0] wd, input logic spam, output int dur);
        int a, n;
        @(negedge clk);
        rw = r; reg_idx = idx; wdata = wd;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        a = cyc;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        check("busy_rise", which ? busy2 : busy1, 1'b1);
        n = 0;
        while (!(which ? done2 : done1) && n < 2000) begin
            @(negedge clk);
            n++;
            start1 = spam && (n % 7 == 0);
            if (start1) begin rw = 1'b1; reg_idx = 8'hEE; wdata = 8'h77; end
        end
        start1 = 1'b0;
        check("done_seen", which ? done2 : done1, 1'b1);
        check("busy_at_done", which ? busy2 : busy1, 1'b0);
        dur = cyc - a;
    endtask

    int dur, l0, c0, nw;

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; rw = 1'b0; reg_idx = 8'h00; wdata = 8'h00;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl1, 1'b0);
        check("rst_sda", sda1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_ackerr", ackerr1, 1'b0);
        check("rst_rdata", rdata1, 8'h00);
        check("rst_scl2", scl2, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Register write
        l0 = logq.size(); c0 = cond_cnt;
        txn(1'b0, 1'b0, 8'h03, 8'h57, 1'b0, dur);
        check("wr_dur", dur, 116 * Q1);
        chk_bytes("wr", l0, 3, 8'hAA, 8'h03, 8'h57);
        check("wr_reg03", regs[8'h03], 8'h57);
        check("wr_ackerr", ackerr1, 1'b0);
        check("wr_conds", cond_cnt - c0, 2);

        // Register read of the same index
        repeat (3) @(negedge clk);
        l0 = logq.size(); c0 = cond_cnt;
        txn(1'b0, 1'b1, 8'h03, 8'h00, 1'b0, dur);
        check("rd_dur", dur, 156 * Q1);
        chk_bytes("rd", l0, 3, 8'hAA, 8'h03, 8'hAB);
        check("rd_rdata", rdata1, 8'h57);
        check("rd_master_nack", mack, 1'b1);
        check("rd_ackerr", ackerr1, 1'b0);
        check("rd_conds", cond_cnt - c0, 3);

        // Wrong device address at CLK_DIV=1
        repeat (3) @(negedge clk);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        l0 = logq.size(); c0 = cond_cnt;
        txn(1'b1, 1'b0, 8'h03, 8'h99, 1'b0, dur);
        check("nack_dur", dur, 44 * Q2);
        chk_bytes("nack", l0, 1, 8'hAC, 8'h00, 8'h00);
        check("nack_ackerr", ackerr2, 1'b1);
        check("nack_reg03", regs[8'h03], 8'h57);
        check("nack_conds", cond_cnt - c0, 2);
        repeat (5) @(negedge clk);
        check("nack_ackerr_held", ackerr2, 1'b1);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // Start requests while busy must be ignored
        l0 = logq.size(); c0 = cond_cnt;
        txn(1'b0, 1'b0, 8'h10, 8'h3C, 1'b1, dur);
        check("spam_dur", dur, 116 * Q1);
        chk_bytes("spam", l0, 3, 8'hAA, 8'h10, 8'h3C);
        check("spam_reg10", regs[8'h10], 8'h3C);
        check("spam_regEE", regs[8'hEE], 8'h00);
        repeat (20) @(negedge clk);
        check("spam_no_queue", busy1, 1'b0);
        check("spam_conds", cond_cnt - c0, 2);

        // Reset in the middle of the index byte
        @(negedge clk);
        rw = 1'b0; reg_idx = 8'h20; wdata = 8'h11; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nw = 0;
        while (!(nbyte == 1 && bitn == 4'd5) && nw < 2000) begin
            @(negedge clk);
            nw++;
        end
        check("rst_reach_idx_bit5", nw < 2000, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_scl", scl1, 1'b0);
        check("midrst_sda", sda1, 1'b0);
        check("midrst_busy", busy1, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        l0 = logq.size();
        txn(1'b0, 1'b0, 8'h01, 8'hA5, 1'b0, dur);
        check("post_rst_dur", dur, 116 * Q1);
        chk_bytes("post_rst", l0, 3, 8'hAA, 8'h01, 8'hA5);
        check("post_rst_reg01", regs[8'h01], 8'hA5);
        check("post_rst_reg20", regs[8'h20], 8'h00);
        check("post_rst_ackerr", ackerr1, 1'b0);

        repeat (4) @(negedge clk);
        check("scl_high_min", viol, 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
